cmos_nvram_ioctl: RTL
=====================

// Module: cmos_nvram_ioctl
// PURPOSE
//  HPS-side save/restore port for the Williams-2 4-bit CMOS (high-score/settings) RAM.
//  It serves ioctl upload reads by packing two CMOS nibbles per byte, and it services
//  ioctl download writes by unpacking each byte into two nibbles.
//  It sits between hps_io (nvram index) and port B of the dual-port CMOS RAM.
//  It also raises a dirty flag when the CPU has modified CMOS since the last save.
// PARAMETERS
//  ADDR_W    10  CMOS nibble address width; the byte space is 2^(ADDR_W-1) bytes.
//  RAM_LAT   1   RAM port-B read latency in cycles; legal range 1..3.
//  NV_INDEX  4   ioctl_index value that selects this block.
// PORTS
//  clk_sys         in   1       System clock (12 MHz domain); the only clock.
//  reset_n         in   1       Asynchronous reset, active low.
//  ioctl_upload    in   1       HPS upload session active.
//  ioctl_download  in   1       HPS download session active.
//  ioctl_index     in   16      Session index; compared against NV_INDEX.
//  ioctl_addr      in   25      Byte address for the current rd/wr.
//  ioctl_rd        in   1       1-cycle read strobe.
//  ioctl_wr        in   1       1-cycle write strobe.
//  ioctl_dout      in   8       Write data from HPS.
//  ioctl_din       out  8       Read data to HPS.
//  ioctl_wait      out  1       Stall to HPS; high while an access is in flight.
//  cmos_cpu_we     in   1       CPU write strobe to CMOS (port A); sets the dirty flag.
//  ram_addr        out  ADDR_W  Port-B nibble address.
//  ram_we          out  1       Port-B write enable.
//  ram_d           out  4       Port-B write nibble.
//  ram_q           in   4       Port-B read nibble.
//  nvram_dirty     out  1       CMOS changed since the last completed upload.
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE. Reset mid-access aborts immediately, with no further ram_we.
//  sel_up = ioctl_upload & (ioctl_index==NV_INDEX); sel_dn = ioctl_download & same compare.
//  In range: ioctl_addr < 2^(ADDR_W-1); byte n maps to nibbles 2n (low) and 2n+1 (high).
//  FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI. Strobes are accepted only in IDLE.
//  Strobes arriving while busy are dropped, not queued.
//  Read, in range (edge T0 samples ioctl_rd & sel_up):
//   - ram_addr=2n, wait=1, enter RD_LO.
//   - After RAM_LAT cycles: lo<=ram_q, ram_addr=2n+1, enter RD_HI.
//   - After RAM_LAT cycles: ioctl_din<={ram_q,lo}, wait=0, enter IDLE.
//   - wait is high for exactly 2*RAM_LAT cycles.
//  Read, out of range: ioctl_din<=8'hFF at T0; no wait, no RAM access.
//  Write, in range (edge T0 samples ioctl_wr & sel_dn):
//   - WR_LO, one cycle: ram_addr=2n, ram_d=dout[3:0], ram_we=1.
//   - WR_HI, one cycle: ram_addr=2n+1, ram_d=dout[7:4], ram_we=1.
//   - Then IDLE. wait is high for both cycles.
//   - ioctl_dout is latched at T0, so the HPS may change it afterwards.
//  Write, out of range: ignored, with no wait.
//  rd and wr in the same cycle: wr wins and rd is dropped.
//  A strobe without a matching index select is ignored.
//  A session ending mid-access does not abort the access; it completes normally.
//  ram_we is 0 in every state except WR_LO and WR_HI. ram_addr holds its last value in IDLE.
//  Dirty flag:
//   - Set on cmos_cpu_we.
//   - Set on any completed download write (CMOS now differs from the saved image).
//   - Cleared on the cycle after sel_up falls, i.e. at upload end.
//   - If cmos_cpu_we coincides with the clear, set wins.
//  Address arithmetic: nibble addr = {ioctl_addr[ADDR_W-2:0], hi_bit}. Upper bits are used only for the range check.
// TESTING
//  1 Reset: hold reset_n=0 mid-RD_HI -> wait=0, din=00, we=0 immediately; IDLE after release.
//  2 RAM preload nib0=3, nib1=A; upload rd addr 0 (RAM_LAT=1) -> wait high 2 cycles, din=8'hA3.
//  3 Download wr addr 5 dout=8'h7C -> we at nib 10 with d=C, then nib 11 with d=7; wait high 2 cycles.
//  4 rd addr 512 (ADDR_W=10) -> din=FF, wait never high, ram_addr unchanged; wr addr 600 -> no we.
//  5 rd and wr strobed in one cycle (both sessions selected) -> write executes, din unchanged;
//    a rd strobe during WR_HI is dropped.
//  6 cmos_cpu_we pulse -> dirty=1; full upload, then sel_up falls -> dirty=0 next cycle;
//    cpu_we on the clear cycle -> dirty stays 1.

Source files
------------

// File: rtl/cmos_nvram_ioctl.sv
// HPS save/restore port for the 4-bit Williams-2 CMOS RAM: packs two nibbles per
// ioctl byte on upload, unpacks on download, and flags CPU-side changes as dirty.
module cmos_nvram_ioctl #(
  parameter int ADDR_W   = 10,
  parameter int RAM_LAT  = 1,
  parameter int NV_INDEX = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic              ioctl_download,
  input  logic [15:0]       ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_rd,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  input  logic              cmos_cpu_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_d,
  input  logic [3:0]        ram_q,
  output logic              nvram_dirty
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI} state_t;

  // Latency is counted from the edge that registers ram_addr.
  localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);

  state_t            state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic [3:0]        lo_nib, lo_nxt;
  logic [3:0]        hi_wr, hi_nxt;
  logic [7:0]        din_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [3:0]        d_nxt;
  logic              we_nxt, wait_nxt, wr_done, dirty_nxt;
  logic              sel_up, sel_dn, sel_up_q, in_range;

  assign sel_up   = ioctl_upload   & (ioctl_index == 16'(NV_INDEX));
  assign sel_dn   = ioctl_download & (ioctl_index == 16'(NV_INDEX));
  assign in_range = (ioctl_addr >> (ADDR_W - 1)) == 25'd0;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lo_nxt    = lo_nib;
    hi_nxt    = hi_wr;
    din_nxt   = ioctl_din;
    addr_nxt  = ram_addr;
    d_nxt     = ram_d;
    we_nxt    = 1'b0;
    wait_nxt  = ioctl_wait;
    wr_done   = 1'b0;
    case (state)
      IDLE: begin
        // A selected write shadows any same-cycle read, even when out of range.
        if (ioctl_wr && sel_dn) begin
          if (in_range) begin
            state_nxt = WR_LO;
            addr_nxt  = {ioctl_addr[ADDR_W-2:0], 1'b0};
            d_nxt     = ioctl_dout[3:0];
            hi_nxt    = ioctl_dout[7:4];
            we_nxt    = 1'b1;
            wait_nxt  = 1'b1;
          end
        end else if (ioctl_rd && sel_up) begin
          if (in_range) begin
            state_nxt = RD_LO;
            addr_nxt  = {ioctl_addr[ADDR_W-2:0], 1'b0};
            cnt_nxt   = 2'd0;
            wait_nxt  = 1'b1;
          end else begin
            din_nxt = 8'hFF;
          end
        end
      end
      RD_LO: begin
        if (cnt == LAT_LAST) begin
          state_nxt = RD_HI;
          lo_nxt    = ram_q;
          addr_nxt  = {ram_addr[ADDR_W-1:1], 1'b1};
          cnt_nxt   = 2'd0;
        end else begin
          cnt_nxt = cnt + 2'd1;
        end
      end
      RD_HI: begin
        if (cnt == LAT_LAST) begin
          state_nxt = IDLE;
          din_nxt   = {ram_q, lo_nib};
          wait_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt + 2'd1;
        end
      end
      WR_LO: begin
        state_nxt = WR_HI;
        addr_nxt  = {ram_addr[ADDR_W-1:1], 1'b1};
        d_nxt     = hi_wr;
        we_nxt    = 1'b1;
      end
      WR_HI: begin
        state_nxt = IDLE;
        wait_nxt  = 1'b0;
        wr_done   = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        wait_nxt  = 1'b0;
      end
    endcase

    // Set beats the end-of-upload clear.
    dirty_nxt = nvram_dirty;
    if (cmos_cpu_we || wr_done)
      dirty_nxt = 1'b1;
    else if (sel_up_q && !sel_up)
      dirty_nxt = 1'b0;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      sel_up_q    <= 1'b0;
      ioctl_din   <= 8'h00;
      ioctl_wait  <= 1'b0;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_d       <= 4'h0;
      nvram_dirty <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      sel_up_q    <= sel_up;
      ioctl_din   <= din_nxt;
      ioctl_wait  <= wait_nxt;
      ram_addr    <= addr_nxt;
      ram_we      <= we_nxt;
      ram_d       <= d_nxt;
      nvram_dirty <= dirty_nxt;
    end
  end

  always_ff @(posedge clk_sys) begin
    lo_nib <= lo_nxt;
    hi_wr  <= hi_nxt;
  end

endmodule
